// File: rtl/usm_bus_pkg.sv
// rtl/usm_bus_pkg.sv - shared bus types and encodings for the dmem arbiter
package usm_bus_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;

    // MemWrite codes as seen by dmem; zero means no write
    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_BYTE = 2'b01;
    localparam logic [1:0] MW_HALF = 2'b10;
    localparam logic [1:0] MW_WORD = 2'b11;

    // SizeLoad codes as seen by dmem; the arbiter passes them through untouched
    localparam logic [2:0] SL_LB  = 3'b000;
    localparam logic [2:0] SL_LH  = 3'b001;
    localparam logic [2:0] SL_LW  = 3'b010;
    localparam logic [2:0] SL_LBU = 3'b011;
    localparam logic [2:0] SL_LHU = 3'b100;

    typedef struct packed {
        logic [1:0]        we;
        logic [2:0]        size;
        logic [BUS_AW-1:0] addr;
        logic [BUS_DW-1:0] wdata;
    } bus_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic valid,
    output logic winner
);

    // A lone requester wins outright; on a tie the port that did not go last wins
    always_comb begin
        valid  = req0 | req1;
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last_owner;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin sharing of dmem between CPU and UART loader
module dmem_arbiter
    import usm_bus_pkg::*;
#(
    // Must match the package bus widths, which size the command register
    parameter int AW = BUS_AW,
    parameter int DW = BUS_DW
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          r0_req,
    input  logic [1:0]    r0_we,
    input  logic [2:0]    r0_size,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,

    input  logic          r1_req,
    input  logic [1:0]    r1_we,
    input  logic [2:0]    r1_size,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    input  logic          r1_lock,

    output logic [1:0]    mem_we,
    output logic [2:0]    mem_size,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    arb_state_t state, state_nx;
    bus_cmd_t   cmd;
    logic       owner;
    logic       last_owner;
    logic       elig0;
    logic       pick_valid;
    logic       pick_winner;
    logic       win;

    assign elig0 = r0_req & ~r1_lock;

    rr_arb2 u_rr_arb2 (
        .req0       (elig0),
        .req1       (r1_req),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    // Grants are only given from IDLE and never while reset is held
    assign win = reset && (state == IDLE) && pick_valid;

    // State, command capture and round-robin history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cmd        <= '0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
        end else begin
            state <= state_nx;
            if (win) begin
                owner      <= pick_winner;
                last_owner <= pick_winner;
                if (pick_winner) begin
                    cmd <= {r1_we, r1_size, r1_addr, r1_wdata};
                end else begin
                    cmd <= {r0_we, r0_size, r0_addr, r0_wdata};
                end
            end
        end
    end

    // Next state plus grant, memory strobe and response muxing
    always_comb begin
        state_nx  = state;
        r0_gnt    = 1'b0;
        r1_gnt    = 1'b0;
        r0_rvalid = 1'b0;
        r1_rvalid = 1'b0;
        r0_rdata  = '0;
        r1_rdata  = '0;
        mem_we    = MW_NONE;
        case (state)
            IDLE: begin
                if (win) begin
                    r0_gnt   = ~pick_winner;
                    r1_gnt   = pick_winner;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                mem_we   = cmd.we;
                state_nx = (cmd.we != MW_NONE) ? IDLE : RESP;
            end
            RESP: begin
                if (owner) begin
                    r1_rvalid = 1'b1;
                    r1_rdata  = mem_rdata;
                end else begin
                    r0_rvalid = 1'b1;
                    r0_rdata  = mem_rdata;
                end
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Address, size and data hold the last command so dmem sees stable lines
    assign mem_size  = cmd.size;
    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed bench for dmem_arbiter
module tb_dmem_arbiter;
    import usm_bus_pkg::*;

    logic        clk;
    logic        reset;
    logic        r0_req, r1_req, r1_lock;
    logic [1:0]  r0_we, r1_we;
    logic [2:0]  r0_size, r1_size;
    logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
    logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [31:0] r0_rdata, r1_rdata;
    logic [1:0]  mem_we;
    logic [2:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] dmem [16];
    logic [31:0] model_mem [16];
    bit          m_last;

    dmem_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_size(r0_size), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_size(r1_size), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .r1_lock(r1_lock),
        .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read dmem stub driven by the arbiter's memory port
    always @(posedge clk) begin
        if (mem_we != MW_NONE) dmem[mem_addr[5:2]] <= mem_wdata;
        mem_rdata <= dmem[mem_addr[5:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bus_cmd_t c0, input bus_cmd_t c1);
        r0_we = c0.we; r0_size = c0.size; r0_addr = c0.addr; r0_wdata = c0.wdata;
        r1_we = c1.we; r1_size = c1.size; r1_addr = c1.addr; r1_wdata = c1.wdata;
    endtask

    // One arbitration round: grant in IDLE, command on dmem in ISSUE, data in RESP
    task automatic do_txn(input bit e0, input bit e1, input bit lk,
                          input bus_cmd_t c0, input bus_cmd_t c1);
        bit       el0;
        bit       w;
        bus_cmd_t c;
        @(negedge clk);
        r0_req = e0; r1_req = e1; r1_lock = lk;
        drive(c0, c1);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_mem_we", mem_we, 0);
        el0 = e0 && !lk;
        if (!el0 && !e1) begin
            chk("nogrant_gnt0", r0_gnt, 0);
            chk("nogrant_gnt1", r1_gnt, 0);
            r0_req = 0; r1_req = 0;
            return;
        end
        // Alternate on contention, otherwise serve whoever is asking
        if (el0 && e1) w = !m_last;
        else           w = e1;
        m_last = w;
        c = w ? c1 : c0;
        chk("gnt0", r0_gnt, !w);
        chk("gnt1", r1_gnt, w);
        @(negedge clk);
        r0_req = 0; r1_req = 0;
        #1;
        chk("issue_busy", busy, 1);
        chk("issue_gnt0", r0_gnt, 0);
        chk("issue_gnt1", r1_gnt, 0);
        chk("issue_we", mem_we, c.we);
        chk("issue_size", mem_size, c.size);
        chk("issue_addr", mem_addr, c.addr);
        chk("issue_wdata", mem_wdata, c.wdata);
        chk("issue_rv0", r0_rvalid, 0);
        chk("issue_rv1", r1_rvalid, 0);
        if (c.we != MW_NONE) begin
            model_mem[c.addr[5:2]] = c.wdata;
            return;
        end
        @(negedge clk);
        #1;
        chk("resp_busy", busy, 1);
        chk("resp_we", mem_we, 0);
        chk("resp_rv0", r0_rvalid, !w);
        chk("resp_rv1", r1_rvalid, w);
        chk("resp_rd0", r0_rdata, w ? 32'h0 : model_mem[c.addr[5:2]]);
        chk("resp_rd1", r1_rdata, w ? model_mem[c.addr[5:2]] : 32'h0);
    endtask

    function automatic bus_cmd_t rnd_cmd();
        bus_cmd_t c;
        logic [1:0] wes [4];
        logic [2:0] szs [5];
        wes[0] = MW_NONE; wes[1] = MW_BYTE; wes[2] = MW_HALF; wes[3] = MW_WORD;
        szs[0] = SL_LB; szs[1] = SL_LH; szs[2] = SL_LW; szs[3] = SL_LBU; szs[4] = SL_LHU;
        c.we    = ($urandom_range(0, 1) == 0) ? MW_NONE : wes[$urandom_range(1, 3)];
        c.size  = szs[$urandom_range(0, 4)];
        c.addr  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        c.wdata = $urandom;
        return c;
    endfunction

    function automatic bus_cmd_t mk(input logic [1:0] we, input logic [31:0] a, input logic [31:0] d);
        bus_cmd_t c;
        c.we = we; c.size = SL_LW; c.addr = a; c.wdata = d;
        return c;
    endfunction

    initial begin
        bus_cmd_t c0, c1, z;
        bit e0, e1, lk;
        for (int i = 0; i < 16; i++) begin
            dmem[i] = $urandom;
            model_mem[i] = dmem[i];
        end
        dmem[4] = 32'hDEADBEEF; model_mem[4] = 32'hDEADBEEF;
        z = '0;
        reset = 0; r0_req = 1; r1_req = 1; r1_lock = 0;
        drive(mk(MW_WORD, 32'h10, 32'h1), z);
        #12;
        chk("rst_gnt0", r0_gnt, 0);
        chk("rst_gnt1", r1_gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rv0", r0_rvalid, 0);
        chk("rst_rd0", r0_rdata, 0);
        r0_req = 0; r1_req = 0;
        @(negedge clk);
        reset = 1;
        m_last = 1;

        // Single read from the CPU port returning the preloaded word
        do_txn(1, 0, 0, mk(MW_NONE, 32'h10, 32'h0), z);
        // Loader write
        do_txn(0, 1, 0, z, mk(MW_WORD, 32'h20, 32'h12345678));
        // Contending reads alternate
        for (int i = 0; i < 4; i++)
            do_txn(1, 1, 0, mk(MW_NONE, 32'h20, 0), mk(MW_NONE, 32'h10, 0));
        // Lock holds port 0 off; releasing it lets port 0 in on the next tie
        do_txn(1, 1, 1, mk(MW_NONE, 32'h10, 0), mk(MW_NONE, 32'h20, 0));
        do_txn(1, 1, 1, mk(MW_NONE, 32'h10, 0), mk(MW_NONE, 32'h24, 0));
        do_txn(1, 1, 0, mk(MW_NONE, 32'h10, 0), mk(MW_NONE, 32'h20, 0));

        // Reset during RESP aborts the read
        @(negedge clk);
        r0_req = 1; r1_req = 0; r1_lock = 0;
        drive(mk(MW_NONE, 32'h10, 0), z);
        #1;
        chk("abort_gnt0", r0_gnt, 1);
        @(negedge clk);
        r0_req = 0;
        @(posedge clk);
        #1;
        reset = 0;
        #1;
        chk("abort_rv0", r0_rvalid, 0);
        chk("abort_rd0", r0_rdata, 0);
        chk("abort_busy", busy, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_we", mem_we, 0);
        @(negedge clk);
        chk("abort_rv0_held", r0_rvalid, 0);
        reset = 1;
        m_last = 1;
        do_txn(1, 1, 0, mk(MW_NONE, 32'h18, 0), mk(MW_NONE, 32'h1C, 0));

        // A one-cycle port-0 request during port-1 ISSUE is never granted
        @(negedge clk);
        r0_req = 0; r1_req = 1;
        drive(mk(MW_WORD, 32'h30, 32'hA5A5A5A5), mk(MW_WORD, 32'h34, 32'hCAFEF00D));
        #1;
        chk("pulse_gnt1", r1_gnt, 1);
        m_last = 1;
        @(negedge clk);
        r1_req = 0; r0_req = 1;
        #1;
        chk("pulse_issue_gnt0", r0_gnt, 0);
        chk("pulse_issue_we", mem_we, MW_WORD);
        chk("pulse_issue_addr", mem_addr, 32'h34);
        model_mem[13] = 32'hCAFEF00D;
        @(negedge clk);
        r0_req = 0;
        #1;
        chk("pulse_idle_gnt0", r0_gnt, 0);
        chk("pulse_idle_we", mem_we, 0);
        chk("pulse_idle_busy", busy, 0);
        @(negedge clk);
        #1;
        chk("pulse_after_we", mem_we, 0);
        chk("pulse_after_busy", busy, 0);
        // Read back both locations to confirm only the loader write landed
        do_txn(1, 0, 0, mk(MW_NONE, 32'h30, 0), z);
        do_txn(0, 1, 0, z, mk(MW_NONE, 32'h34, 0));

        // Randomized traffic against the reference model
        for (int i = 0; i < 60; i++) begin
            e0 = 1'($urandom_range(0, 1));
            e1 = 1'($urandom_range(0, 1));
            lk = ($urandom_range(0, 3) == 0);
            c0 = rnd_cmd();
            c1 = rnd_cmd();
            do_txn(e0, e1, lk, c0, c1);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
